// File: rtl/if_pkg.sv
// Shared types for the instruction fetch front end.
//   if_state_e    : fetch controller states
//   PC_STEP       : byte increment between sequential instructions
//   fetch_entry_t : one buffered fetch, {pc, instr}
package if_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } if_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering fetched instructions between the PC stage and decode.
// Ports:
//   clk_i, rst_i       clock (rising edge) / asynchronous active-high reset
//   push_i, wdata_i    write one entry (caller guarantees ~full_o or a same-cycle pop)
//   pop_i              discard the head entry (caller guarantees ~empty_o)
//   flush_i            drop all entries; overrides push/pop
//   rdata_o            head entry
//   full_o, empty_o    occupancy flags
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            // Storage is left alone; only the bookkeeping is cleared.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + 1'b1;
            end else if (pop_i && !push_i) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, addresses instruction memory, buffers
// {pc, instr} in a small FIFO and hands it to decode over valid/ready.
// Ports:
//   Clk, Reset                 clock / asynchronous active-high reset
//   fetch_en                   allow fetching (0 holds the PC; buffer still drains)
//   redirect_valid/redirect_pc one-cycle PC reload with buffer flush
//   imem_addr/imem_rdata       instruction memory port (read data is combinational)
//   if_valid/if_ready          handshake towards decode
//   if_instr/if_pc/if_pc_plus4 head of the fetch buffer
//   halted                     PC ran past the end of instruction memory
//
// state  | meaning
// IDLE   | fetch disabled, PC held
// FETCH  | fetching sequentially
// HALTED | PC out of memory range; waits for an in-range redirect
module instruction_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 128,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        halted
);

    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    if_state_e    state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         halted_q;

    logic         in_range;
    logic         redirect_in_range;
    logic [31:0]  redirect_target;
    logic         fetch_active;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign redirect_target   = {redirect_pc[31:2], 2'b00};
    assign in_range          = (pc_q[31:2] < IMEM_LIMIT);
    assign redirect_in_range = (redirect_pc[31:2] < IMEM_LIMIT);

    // fetch_en acts in the same cycle so the first push lands on the first edge
    // after reset release, before the FSM has left IDLE.
    assign fetch_active = fetch_en && (state_q != HALTED);
    assign pop          = if_valid && if_ready && !redirect_valid;
    assign push         = fetch_active && in_range && !redirect_valid && (!fifo_full || pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (redirect_valid) begin
                if (state_q == HALTED && !redirect_in_range) begin
                    state_q  <= HALTED;
                    halted_q <= 1'b1;
                end else if (state_q == HALTED || fetch_en) begin
                    state_q  <= FETCH;
                    halted_q <= 1'b0;
                end else begin
                    state_q  <= IDLE;
                    halted_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE, FETCH: begin
                        if (!fetch_en) begin
                            state_q  <= IDLE;
                            halted_q <= 1'b0;
                        end else if (!in_range) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q  <= FETCH;
                            halted_q <= 1'b0;
                        end
                    end
                    HALTED: begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                    default: begin
                        state_q  <= IDLE;
                        halted_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign imem_addr   = pc_q;
    assign if_valid    = !fifo_empty;
    assign if_instr    = head.instr;
    assign if_pc       = head.pc;
    assign if_pc_plus4 = head.pc + PC_STEP;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_q[$];
    logic [31:0] imem [128];

    instruction_fetch_unit dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .halted         (halted)
    );

    assign imem_rdata = imem[imem_addr[8:2]];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Expected (pc, instr) pair; instr = word index * 3.
    task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitor: checks each accepted head against the next expectation.
    always @(negedge Clk) begin
        logic [63:0] e;
        if (!Reset && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got pc=%h instr=%h, required no output", if_pc, if_instr);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", if_pc, e[63:32]);
                check("out_instr", if_instr, e[31:0]);
                check("out_pc_plus4", if_pc_plus4, e[63:32] + 32'd4);
            end
        end
    end

    task automatic do_reset();
        Reset          = 1'b1;
        fetch_en       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();
        check("leftover_expectations", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc_plus4", if_pc_plus4, 32'h4);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            step();
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            imem[i] = 32'(i) * 32'd3;
        end

        // 1: latency and back-to-back delivery
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b1;
        expect_fetch(32'h0, 32'd0);
        expect_fetch(32'h4, 32'd3);
        expect_fetch(32'h8, 32'd6);
        Reset = 1'b0;
        step();
        check("t1_first_valid", {31'd0, if_valid}, 32'd1);
        step();
        step();
        fetch_en = 1'b0;
        drain("t1_drain");

        // 2: stall fills the buffer, PC holds, release drains without gaps
        do_reset();
        fetch_en = 1'b1;
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t2_imem_addr_held", imem_addr, 32'h8);
        check("t2_head_pc", if_pc, 32'h0);
        expect_fetch(32'h0, 32'd0);
        expect_fetch(32'h4, 32'd3);
        expect_fetch(32'h8, 32'd6);
        if_ready = 1'b1;
        step();
        fetch_en = 1'b0;
        step();
        step();
        check("t2_no_gap_drain", 32'(exp_q.size()), 32'd0);
        check("t2_empty_after", {31'd0, if_valid}, 32'd0);

        // 3: redirect while the buffer is full
        do_reset();
        fetch_en = 1'b1;
        Reset = 1'b0;
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        step();
        redirect_valid = 1'b0;
        check("t3_flush_valid", {31'd0, if_valid}, 32'd0);
        check("t3_redirect_addr", imem_addr, 32'h40);
        expect_fetch(32'h40, 32'd48);
        step();
        fetch_en = 1'b0;
        if_ready = 1'b1;
        drain("t3_drain");

        // 4: run off the end of memory, halt, redirect back in
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            expect_fetch(32'(i) * 32'd4, 32'(i) * 32'd3);
        end
        Reset = 1'b0;
        for (int i = 0; i < 300 && !halted; i++) step();
        check("t4_halted", {31'd0, halted}, 32'd1);
        check("t4_halt_addr", imem_addr, 32'h200);
        step();
        step();
        step();
        check("t4_all_delivered", 32'(exp_q.size()), 32'd0);
        check("t4_no_push_halted", {31'd0, if_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        expect_fetch(32'h10, 32'd12);
        step();
        redirect_valid = 1'b0;
        check("t4_unhalted", {31'd0, halted}, 32'd0);
        step();
        fetch_en = 1'b0;
        drain("t4_drain");

        // 5: fetch_en low mid-stream freezes the PC, resumes where it stopped
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b1;
        expect_fetch(32'h0, 32'd0);
        expect_fetch(32'h4, 32'd3);
        expect_fetch(32'h8, 32'd6);
        expect_fetch(32'hC, 32'd9);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        fetch_en = 1'b0;
        step();
        step();
        step();
        check("t5_pc_frozen", imem_addr, 32'h10);
        check("t5_drained", 32'(exp_q.size()), 32'd0);
        check("t5_empty", {31'd0, if_valid}, 32'd0);
        expect_fetch(32'h10, 32'd12);
        expect_fetch(32'h14, 32'd15);
        fetch_en = 1'b1;
        step();
        step();
        fetch_en = 1'b0;
        drain("t5_drain");

        // 6: redirect while idle, halt with full buffer, reset mid-cycle
        do_reset();
        Reset = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_01FB;
        step();
        redirect_valid = 1'b0;
        step();
        check("t6_idle_redirect_addr", imem_addr, 32'h1F8);
        check("t6_idle_no_push", {31'd0, if_valid}, 32'd0);
        fetch_en = 1'b1;
        for (int i = 0; i < 10 && !halted; i++) step();
        check("t6_halted", {31'd0, halted}, 32'd1);
        check("t6_full_head_pc", if_pc, 32'h1F8);
        check("t6_full_head_instr", if_instr, 32'd378);
        #2;
        Reset = 1'b1;
        #1;
        check("t6_async_valid", {31'd0, if_valid}, 32'd0);
        check("t6_async_halted", {31'd0, halted}, 32'd0);
        check("t6_async_addr", imem_addr, 32'h0);
        step();
        if_ready = 1'b1;
        expect_fetch(32'h0, 32'd0);
        Reset = 1'b0;
        step();
        fetch_en = 1'b0;
        drain("t6_drain");

        if_ready = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
